fp_result_queue: RTL and testbench
==================================

# fp_result_queue

Registered result stage directly downstream of the combinational FP ALU. Captures each ALU result (arithmetic word or compare bit) together with its exception flags and a requester tag into a small FIFO, and presents entries to the consumer over a valid/ready handshake. It also keeps sticky, software-clearable accumulated exception flags in the style of an fflags register. It is the first clocked point after the ALU and decouples ALU issue from result consumption.

## Interface
- addr_width, 3: width of op_code_i; matches the ALU op-code field.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TAG_W, 4: width of the requester tag carried with each result.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  ALU outputs below are valid this cycle.
- in_ready_o  out  1  queue can accept a push this cycle.
- op_code_i  in  addr_width  op code applied to the ALU (0 FADD, 1 FSUB, 2 FMUL, 3 FMADD, 4 FMSUB, 5 FEQ, 6 FLT, 7 FLE).
- fp_result_i  in  32  ALU fp_result_o.
- overflow_i / underflow_i / invalid_i  in  1 each  ALU exception outputs.
- cmp_result_i  in  1  ALU compare output.
- tag_i  in  TAG_W  requester tag.
- out_valid_o  out  1  head entry available.
- out_ready_i  in  1  consumer accepts the head entry.
- out_data_o  out  32  head result word.
- out_is_cmp_o  out  1  head entry came from a compare op (5–7).
- out_flags_o  out  3  head flags {invalid, overflow, underflow}.
- out_tag_o  out  TAG_W  head tag.
- flags_o  out  3  sticky accumulated {invalid, overflow, underflow}.
- flags_clr_i  in  1  clears flags_o.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Push when in_valid_i && in_ready_o. Pop when out_valid_o && out_ready_i.
- in_ready_o = (count_o < DEPTH). There is no full-pass-through: when full, a push is not accepted, even if a pop occurs in the same cycle.
- out_valid_o = (count_o != 0). The head is a registered output, with no combinational bypass from the inputs.
- Entry formation at push:
  - Compare ops (5–7): data = {31'b0, cmp_result_i}, is_cmp = 1, flags = 3'b000.
  - Arithmetic ops (0–4): data = fp_result_i, is_cmp = 0, flags = {invalid_i, overflow_i, underflow_i}.
- Read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. count_o is updated as count + push − pop.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and the count is unchanged.
- Sticky flags:
  - On push: flags_o |= entry flags.
  - flags_clr_i alone: flags_o ← 0.
  - flags_clr_i together with a push: flags_o ← entry flags (clear first, then set).
- When out_valid_o = 1 and out_ready_i = 0, the out_* outputs hold stable until the pop.
- Inputs are ignored when in_valid_i = 0. tag_i and op_code_i are sampled only on a push.

## Timing
- Reset values (asynchronous, while rst_ni = 0): pointers 0, count_o 0, out_valid_o 0, out_data_o 0, out_is_cmp_o 0, out_flags_o 0, out_tag_o 0, flags_o 0.
- in_ready_o is 1 once reset has been released.
- Reset asserted mid-operation discards all entries immediately; no partial state survives.
- Latency: a push at edge N makes out_valid_o high after edge N (one cycle) when the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- in_ready_o depends only on registered count. It never depends combinationally on out_ready_i.
- out_* are driven from storage indexed by the read pointer; they change only on a clock edge or on reset.

## Test plan
- Reset then single push FADD: fp_result_i = 32'h40400000, flags 000, tag 3 → next cycle out_valid_o = 1, out_data_o = 32'h40400000, out_tag_o = 3, out_is_cmp_o = 0, count_o = 1; pop → count_o = 0.
- Fill DEPTH = 4 with tags 0..3 while out_ready_i = 0 → in_ready_o = 0 with count_o = 4. A 5th push is held off. Drain → tags come out in order 0,1,2,3, and head outputs stay stable during stall cycles.
- Push FLT with cmp_result_i = 1 and fp_result_i = 32'hDEADBEEF → out_data_o = 32'h00000001, out_is_cmp_o = 1, out_flags_o = 000.
- Push FMUL with overflow_i = 1, then FADD with invalid_i = 1 → flags_o = 3'b110. Assert flags_clr_i in the same cycle as a push with underflow_i = 1 → flags_o = 3'b001.
- Continuous push and pop for 10 cycles starting at count 2 → count_o stays 2, pointers wrap past DEPTH, and data order is preserved.
- Assert rst_ni = 0 with 3 entries queued → immediately out_valid_o = 0, count_o = 0, flags_o = 0. After release, in_ready_o = 1.

Source files
------------

// File: rtl/fp_result_queue_if.sv
// Valid/ready result stream between the FP ALU issue side, the result queue and its consumer.
// Signal suffixes are named from the queue's point of view.
interface fp_result_queue_if #(
    parameter int addr_width = 3,
    parameter int TAG_W      = 4
) ();
    // Push side: ALU outputs entering the queue
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [addr_width-1:0] op_code_i;
    logic [31:0]           fp_result_i;
    logic                  overflow_i;
    logic                  underflow_i;
    logic                  invalid_i;
    logic                  cmp_result_i;
    logic [TAG_W-1:0]      tag_i;

    // Pop side: registered head entry presented to the consumer
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [31:0]           out_data_o;
    logic                  out_is_cmp_o;
    logic [2:0]            out_flags_o;
    logic [TAG_W-1:0]      out_tag_o;

    modport master (
        output in_valid_i, op_code_i, fp_result_i, overflow_i, underflow_i,
               invalid_i, cmp_result_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_is_cmp_o, out_flags_o, out_tag_o
    );

    modport slave (
        input  in_valid_i, op_code_i, fp_result_i, overflow_i, underflow_i,
               invalid_i, cmp_result_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_is_cmp_o, out_flags_o, out_tag_o
    );
endinterface

// File: rtl/fp_result_queue.sv
// Registered FIFO stage behind the combinational FP ALU: captures result, flags and tag,
// serves them over valid/ready, and keeps fflags-style sticky exception flags.
module fp_result_queue #(
    parameter int addr_width = 3,
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fp_result_queue_if.slave       q,
    input  logic                   flags_clr_i,
    output logic [2:0]             flags_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL_CNT     = CNT_W'(DEPTH);
    localparam logic [addr_width-1:0] FIRST_CMP_OP = addr_width'(5);

    typedef struct packed {
        logic [31:0]      data;
        logic             is_cmp;
        logic [2:0]       flags;   // {invalid, overflow, underflow}
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       flags_q, flags_d;
    logic             push, pop;

    // Ready depends only on the registered count, so a full queue refuses a push even if it pops.
    assign q.in_ready_o  = (count_q < FULL_CNT);
    assign q.out_valid_o = (count_q != '0);
    assign push          = q.in_valid_i && q.in_ready_o;
    assign pop           = q.out_valid_o && q.out_ready_i;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
    always_comb begin
        new_entry     = '0;
        new_entry.tag = q.tag_i;
        if (q.op_code_i >= FIRST_CMP_OP) begin
            new_entry.data   = {31'b0, q.cmp_result_i};
            new_entry.is_cmp = 1'b1;
        end else begin
            new_entry.data  = q.fp_result_i;
            new_entry.flags = {q.invalid_i, q.overflow_i, q.underflow_i};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        // Clear takes effect before the pushed entry's flags are merged in.
        flags_d  = flags_clr_i ? 3'b000 : flags_q;
        if (push) begin
            flags_d = flags_d | new_entry.flags;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
        end
    end

    // NOTE: storage is reset because the head outputs are read straight from it and must be zero in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign q.out_data_o   = head.data;
    assign q.out_is_cmp_o = head.is_cmp;
    assign q.out_flags_o  = head.flags;
    assign q.out_tag_o    = head.tag;
    assign flags_o        = flags_q;
    assign count_o        = count_q;
endmodule

// File: tb/tb_fp_result_queue.sv
// Self-checking bench for fp_result_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fp_result_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0]      data;
        logic             is_cmp;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic       clk_i;
    logic       rst_ni;
    logic       flags_clr_i;
    logic [2:0] flags_o;
    logic [2:0] count_o;

    int   n_checks;
    int   n_errors;
    exp_t mq[$];
    logic [2:0] mflags;

    fp_result_queue_if #(.addr_width(3), .TAG_W(TAG_W)) bus ();

    fp_result_queue #(.addr_width(3), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .q           (bus),
        .flags_clr_i (flags_clr_i),
        .flags_o     (flags_o),
        .count_o     (count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] res,
                         input logic inv, input logic ov, input logic un,
                         input logic cmp, input logic [TAG_W-1:0] tag);
        bus.in_valid_i   = v;
        bus.op_code_i    = op;
        bus.fp_result_i  = res;
        bus.invalid_i    = inv;
        bus.overflow_i   = ov;
        bus.underflow_i  = un;
        bus.cmp_result_i = cmp;
        bus.tag_i        = tag;
    endtask

    task automatic compare_all();
        check("in_ready", bus.in_ready_o, mq.size() < DEPTH);
        check("out_valid", bus.out_valid_o, mq.size() != 0);
        check("count", count_o, mq.size());
        check("flags", flags_o, mflags);
        if (mq.size() != 0) begin
            check("head_data", bus.out_data_o, mq[0].data);
            check("head_is_cmp", bus.out_is_cmp_o, mq[0].is_cmp);
            check("head_flags", bus.out_flags_o, mq[0].flags);
            check("head_tag", bus.out_tag_o, mq[0].tag);
        end
    endtask

    // Advance one clock: predict the handshake from the model, update it at the edge, then compare.
    task automatic tick();
        exp_t e;
        logic do_push;
        logic do_pop;
        do_push = bus.in_valid_i && (mq.size() < DEPTH);
        do_pop  = bus.out_ready_i && (mq.size() != 0);
        e.tag   = bus.tag_i;
        if (bus.op_code_i inside {3'd5, 3'd6, 3'd7}) begin
            e.data = 32'd1 & {31'b0, bus.cmp_result_i};
            e.is_cmp = 1'b1;
            e.flags  = 3'b000;
        end else begin
            e.data   = bus.fp_result_i;
            e.is_cmp = 1'b0;
            e.flags  = {bus.invalid_i, bus.overflow_i, bus.underflow_i};
        end
        @(posedge clk_i);
        if (flags_clr_i) mflags = 3'b000;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(e);
            mflags = mflags | e.flags;
        end
        #1;
        compare_all();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mflags   = 3'b000;
        rst_ni   = 1'b0;
        flags_clr_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Reset values
        #12;
        check("rst_out_valid", bus.out_valid_o, 1'b0);
        check("rst_count", count_o, 3'd0);
        check("rst_out_data", bus.out_data_o, 32'h0);
        check("rst_out_tag", bus.out_tag_o, 4'd0);
        check("rst_flags", flags_o, 3'b000);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        compare_all();

        // Single FADD push, then pop
        drive(1'b1, 3'd0, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        tick();
        check("fadd_data", bus.out_data_o, 32'h40400000);
        check("fadd_tag", bus.out_tag_o, 4'd3);
        check("fadd_count", count_o, 3'd1);
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        check("fadd_pop_count", count_o, 3'd0);

        // Fill with tags 0..3, attempt a 5th push, then drain with stalls
        bus.out_ready_i = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, 3'd2, 32'h3F800000 + t, 1'b0, 1'b0, 1'b0, 1'b0, 4'(t));
            tick();
        end
        drive(1'b1, 3'd1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
        tick();
        check("full_count", count_o, 3'd4);
        check("full_in_ready", bus.in_ready_o, 1'b0);
        bus.in_valid_i = 1'b0;
        begin
            int k;
            k = 0;
            for (int i = 0; i < 8; i++) begin
                bus.out_ready_i = 1'(i % 2);
                if (bus.out_ready_i) begin
                    check("drain_tag", bus.out_tag_o, 4'(k));
                    k++;
                end
                tick();
            end
        end
        check("drained_count", count_o, 3'd0);

        // Compare op ignores fp_result_i
        bus.out_ready_i = 1'b0;
        drive(1'b1, 3'd6, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        tick();
        check("flt_data", bus.out_data_o, 32'h00000001);
        check("flt_is_cmp", bus.out_is_cmp_o, 1'b1);
        check("flt_flags", bus.out_flags_o, 3'b000);

        // Sticky flags, clear, and clear-with-push
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        flags_clr_i     = 1'b1;
        tick();
        flags_clr_i = 1'b0;
        drive(1'b1, 3'd2, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        tick();
        drive(1'b1, 3'd0, 32'h7FC00000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        tick();
        check("sticky_110", flags_o, 3'b110);
        flags_clr_i = 1'b1;
        drive(1'b1, 3'd3, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        tick();
        flags_clr_i = 1'b0;
        check("clr_push_001", flags_o, 3'b001);
        bus.in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Steady push+pop at count 2 across pointer wrap
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd4, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 4'(8 + i));
            tick();
        end
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'd0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 4'(i));
            tick();
            check("stream_count", count_o, 3'd2);
        end

        // Asynchronous reset with 3 entries queued
        bus.out_ready_i = 1'b0;
        drive(1'b1, 3'd2, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        tick();
        check("pre_rst_count", count_o, 3'd3);
        bus.in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid_o, 1'b0);
        check("mid_rst_count", count_o, 3'd0);
        check("mid_rst_flags", flags_o, 3'b000);
        mq.delete();
        mflags = 3'b000;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst_in_ready", bus.in_ready_o, 1'b1);
        compare_all();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            flags_clr_i     = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
